// File: rtl/bidirectional_shift_deserializer_if.sv
// Parallel-side and serial-side signal bundle of the shift-register link receiver.
// The slave modport is the receiver; the master modport is whoever drives the link and consumes words.
interface bidirectional_shift_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             start;
  logic             shiftLeft;
  logic             serialIn;
  logic             ready;
  logic             clearOverrun;
  logic [WIDTH-1:0] dataout;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport slave (
    input  enable,
    input  start,
    input  shiftLeft,
    input  serialIn,
    input  ready,
    input  clearOverrun,
    output dataout,
    output valid,
    output busy,
    output overrun
  );

  modport master (
    output enable,
    output start,
    output shiftLeft,
    output serialIn,
    output ready,
    output clearOverrun,
    input  dataout,
    input  valid,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/bidirectional_shift_deserializer.sv
// Serial-link receiver: assembles WIDTH-bit frames MSB- or LSB-first into a
// single output word register with valid/ready handshake and sticky overrun.
module bidirectional_shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  bidirectional_shift_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             complete;
  logic [WIDTH-1:0] shifted;

  // One-bit insertion: MSB-first pushes in at bit 0 so the first bit walks up
  // to the top; LSB-first pushes in at the top so the first bit walks down to 0.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh,
                                                input logic             msb_first,
                                                input logic             bit_in);
    logic [WIDTH-1:0] r;
    if (msb_first) r = {sh[WIDTH-2:0], bit_in};
    else           r = {bit_in, sh[WIDTH-1:1]};
    return r;
  endfunction

  assign shifted = shift_in(sh_q, dir_q, bus.serialIn);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    dataout_d = dataout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;

    // A qualified start always opens a fresh frame, discarding any partial one.
    if (bus.enable) begin
      if (bus.start) begin
        dir_d   = bus.shiftLeft;
        sh_d    = shift_in('0, bus.shiftLeft, bus.serialIn);
        cnt_d   = ONE;
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
        sh_d = shifted;
        if (cnt_q == LAST_IDX) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    if (valid_q && bus.ready) valid_d = 1'b0;
    if (bus.clearOverrun)     overrun_d = 1'b0;

    // A consume on the same edge frees the buffer for the word completing now.
    if (complete) begin
      if (!valid_q || bus.ready) begin
        dataout_d = shifted;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.dataout = dataout_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_bidirectional_shift_deserializer.sv
// Bench for the serial-link receiver: directed scenarios plus a randomized run
// against a frame-level reference model built from bit queues.
module tb_bidirectional_shift_deserializer;

  localparam int W = 8;

  logic clock;
  logic reset;

  bidirectional_shift_deserializer_if #(.WIDTH(W)) bus();

  bidirectional_shift_deserializer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  bit         mbits[$];
  bit         m_dir;
  bit         m_busy;
  logic [W-1:0] m_data;
  bit         m_valid;
  bit         m_ovr;

  task automatic model_reset();
    mbits.delete();
    m_dir   = 0;
    m_busy  = 0;
    m_data  = '0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  task automatic model_step();
    bit           done;
    bit           consume;
    logic [W-1:0] w;
    done    = 0;
    w       = '0;
    consume = m_valid && (bus.ready === 1'b1);
    if (bus.enable) begin
      if (bus.start) begin
        mbits.delete();
        mbits.push_back(bus.serialIn);
        m_dir  = bus.shiftLeft;
        m_busy = 1;
      end else if (m_busy) begin
        mbits.push_back(bus.serialIn);
        if (mbits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            if (m_dir) w[W-1-i] = mbits[i];
            else       w[i]     = mbits[i];
          end
          done   = 1;
          m_busy = 0;
          mbits.delete();
        end
      end
    end
    if (consume) m_valid = 0;
    if (bus.clearOverrun) m_ovr = 0;
    if (done) begin
      if (!m_valid) begin
        m_data  = w;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable       = 1'b0;
    bus.start        = 1'b0;
    bus.shiftLeft    = 1'b0;
    bus.serialIn     = 1'b0;
    bus.ready        = 1'b0;
    bus.clearOverrun = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic st, input logic dir);
    bus.enable    = 1'b1;
    bus.start     = st;
    bus.shiftLeft = dir;
    bus.serialIn  = b;
    cycle();
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic dir,
                            input logic rdy_last, input logic clr_last);
    for (int i = 0; i < W; i++) begin
      bus.ready        = (i == W-1) ? rdy_last : 1'b0;
      bus.clearOverrun = (i == W-1) ? clr_last : 1'b0;
      send_bit(dir ? word[W-1-i] : word[i], (i == 0), dir);
    end
    idle_inputs();
  endtask

  task automatic consume_word();
    bus.ready = 1'b1;
    cycle();
    bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    nvec++; if (bus.dataout !== 8'h00) begin nerr++; $display("FAIL reset_dataout: got %h expected 00", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b0)  begin nerr++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    nvec++; if (bus.busy    !== 1'b0)  begin nerr++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    nvec++; if (bus.overrun !== 1'b0)  begin nerr++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    reset = 1'b1;
    cycle();
    // Put a word in the buffer and raise overrun so reset has something to clear
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL midframe_busy: got %b expected 1", bus.busy); end
    nvec++; if (bus.overrun !== 1'b1) begin nerr++; $display("FAIL pre_reset_overrun: got %b expected 1", bus.overrun); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    nvec++; if (bus.dataout !== 8'h00) begin nerr++; $display("FAIL async_reset_dataout: got %h expected 00", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b0)  begin nerr++; $display("FAIL async_reset_valid: got %b expected 0", bus.valid); end
    nvec++; if (bus.busy    !== 1'b0)  begin nerr++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    nvec++; if (bus.overrun !== 1'b0)  begin nerr++; $display("FAIL async_reset_overrun: got %b expected 0", bus.overrun); end
    #1 reset = 1'b1;
    idle_inputs();
    cycle();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    nvec++; if (bus.dataout !== 8'h5A) begin nerr++; $display("FAIL post_reset_frame: got %h expected 5A", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL post_reset_valid: got %b expected 1", bus.valid); end
    consume_word();
  endtask

  task automatic test_msb_first();
    send_frame(8'hB6, 1'b1, 1'b0, 1'b0);
    nvec++; if (bus.dataout !== 8'hB6) begin nerr++; $display("FAIL msb_dataout: got %h expected B6", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL msb_valid: got %b expected 1", bus.valid); end
    nvec++; if (bus.busy    !== 1'b0)  begin nerr++; $display("FAIL msb_busy: got %b expected 0", bus.busy); end
    consume_word();
    nvec++; if (bus.valid   !== 1'b0)  begin nerr++; $display("FAIL msb_consumed: got %b expected 0", bus.valid); end
    nvec++; if (bus.dataout !== 8'hB6) begin nerr++; $display("FAIL msb_hold_after_consume: got %h expected B6", bus.dataout); end
  endtask

  task automatic test_lsb_first();
    // 8'h6D sent LSB-first is the bit stream 1,0,1,1,0,1,1,0
    send_frame(8'h6D, 1'b0, 1'b0, 1'b0);
    nvec++; if (bus.dataout !== 8'h6D) begin nerr++; $display("FAIL lsb_dataout: got %h expected 6D", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL lsb_valid: got %b expected 1", bus.valid); end
    consume_word();
  endtask

  task automatic test_stall();
    logic [W-1:0] word;
    word = 8'hB6;
    for (int i = 0; i < 4; i++) send_bit(word[W-1-i], (i == 0), 1'b1);
    bus.enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.serialIn  = ~bus.serialIn;
      bus.shiftLeft = ~bus.shiftLeft;
      cycle();
      nvec++; if (bus.busy  !== 1'b1) begin nerr++; $display("FAIL stall_busy: got %b expected 1", bus.busy); end
      nvec++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL stall_valid: got %b expected 0", bus.valid); end
    end
    for (int i = 4; i < W; i++) begin
      send_bit(word[W-1-i], 1'b0, (i % 2 == 0) ? 1'b0 : 1'b1);
      if (i < W-1) begin
        nvec++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL stall_early_valid: got %b expected 0", bus.valid); end
      end
    end
    idle_inputs();
    nvec++; if (bus.dataout !== 8'hB6) begin nerr++; $display("FAIL stall_dataout: got %h expected B6", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL stall_done_valid: got %b expected 1", bus.valid); end
    nvec++; if (bus.busy    !== 1'b0)  begin nerr++; $display("FAIL stall_done_busy: got %b expected 0", bus.busy); end
    consume_word();
  endtask

  task automatic test_overrun();
    send_frame(8'hB6, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    nvec++; if (bus.dataout !== 8'hB6) begin nerr++; $display("FAIL ovr_dataout: got %h expected B6", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL ovr_valid: got %b expected 1", bus.valid); end
    nvec++; if (bus.overrun !== 1'b1)  begin nerr++; $display("FAIL ovr_flag: got %b expected 1", bus.overrun); end
    consume_word();
    nvec++; if (bus.valid   !== 1'b0)  begin nerr++; $display("FAIL ovr_consume: got %b expected 0", bus.valid); end
    nvec++; if (bus.overrun !== 1'b1)  begin nerr++; $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); end
    bus.clearOverrun = 1'b1;
    cycle();
    bus.clearOverrun = 1'b0;
    nvec++; if (bus.overrun !== 1'b0)  begin nerr++; $display("FAIL ovr_clear: got %b expected 0", bus.overrun); end
    // Consume on the completion edge frees room for the second word
    send_frame(8'hB6, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    nvec++; if (bus.dataout !== 8'h3C) begin nerr++; $display("FAIL ovr_same_edge_dataout: got %h expected 3C", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL ovr_same_edge_valid: got %b expected 1", bus.valid); end
    nvec++; if (bus.overrun !== 1'b0)  begin nerr++; $display("FAIL ovr_same_edge_flag: got %b expected 0", bus.overrun); end
    // Clear and a fresh overrun on the same edge: the set wins
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    nvec++; if (bus.overrun !== 1'b1)  begin nerr++; $display("FAIL ovr_set_wins: got %b expected 1", bus.overrun); end
    nvec++; if (bus.dataout !== 8'h3C) begin nerr++; $display("FAIL ovr_dropped_word: got %h expected 3C", bus.dataout); end
    consume_word();
    bus.clearOverrun = 1'b1;
    cycle();
    bus.clearOverrun = 1'b0;
  endtask

  task automatic test_restart();
    logic [W-1:0] word;
    word = 8'hA5;
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      send_bit(word[W-1-i], (i == 0), 1'b1);
      if (i < W-1) begin
        nvec++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL restart_partial_valid: got %b expected 0", bus.valid); end
      end
    end
    idle_inputs();
    nvec++; if (bus.dataout !== 8'hA5) begin nerr++; $display("FAIL restart_dataout: got %h expected A5", bus.dataout); end
    nvec++; if (bus.valid   !== 1'b1)  begin nerr++; $display("FAIL restart_valid: got %b expected 1", bus.valid); end
    nvec++; if (bus.overrun !== 1'b0)  begin nerr++; $display("FAIL restart_overrun: got %b expected 0", bus.overrun); end
    consume_word();
  endtask

  task automatic test_random();
    logic st;
    for (int n = 0; n < 600; n++) begin
      bus.enable       = ($urandom_range(0, 9) < 7);
      st               = m_busy ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      if (m_busy && mbits.size() == W-1) st = 1'b0;
      bus.start        = st;
      bus.shiftLeft    = $urandom_range(0, 1);
      bus.serialIn     = $urandom_range(0, 1);
      bus.ready        = ($urandom_range(0, 3) == 0);
      bus.clearOverrun = ($urandom_range(0, 15) == 0);
      cycle();
      nvec++; if (bus.dataout !== m_data)  begin nerr++; $display("FAIL rand_dataout[%0d]: got %h expected %h", n, bus.dataout, m_data); end
      nvec++; if (bus.valid   !== m_valid) begin nerr++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, bus.valid, m_valid); end
      nvec++; if (bus.busy    !== m_busy)  begin nerr++; $display("FAIL rand_busy[%0d]: got %b expected %b", n, bus.busy, m_busy); end
      nvec++; if (bus.overrun !== m_ovr)   begin nerr++; $display("FAIL rand_overrun[%0d]: got %b expected %b", n, bus.overrun, m_ovr); end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_overrun();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
